// File: rtl/i2c_bus_arbiter_if.sv
// Requester/controller bundle for the shared i2c_controller arbiter.
// master: the requesters plus the i2c_controller (the environment around the arbiter).
// slave:  the arbiter itself.
interface i2c_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    // Requester side
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   req_rw;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic [7:0]           rdata;

    // i2c_controller side
    logic                 m_enable;
    logic [6:0]           m_addr;
    logic [7:0]           m_data_in;
    logic                 m_rw;
    logic [7:0]           m_data_out;
    logic                 m_ready;

    modport master (
        output req, req_addr, req_wdata, req_rw, m_data_out, m_ready,
        input  gnt, done, err, rdata, m_enable, m_addr, m_data_in, m_rw
    );

    modport slave (
        input  req, req_addr, req_wdata, req_rw, m_data_out, m_ready,
        output gnt, done, err, rdata, m_enable, m_addr, m_data_in, m_rw
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ requesters.
// Sequences the controller's enable/ready handshake, aborts stuck transactions
// after TIMEOUT cycles and returns read data plus done/err to the winner.
module i2c_bus_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    i2c_bus_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               m_enable_q, m_enable_d;
    logic [6:0]         m_addr_q, m_addr_d;
    logic [7:0]         m_data_in_q, m_data_in_d;
    logic               m_rw_q, m_rw_d;

    // Per-requester views of the flattened address/data buses
    logic [6:0] addr_arr  [NUM_REQ];
    logic [7:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = bus.req_addr[7*g +: 7];
        assign wdata_arr[g] = bus.req_wdata[8*g +: 8];
    end

    // Round-robin pick: first set req scanning upward from rr_ptr, wrapping
    logic             pick_valid_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic [IDX_W-1:0] cand_c;

    always_comb begin
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        cand_c       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_valid_c && bus.req[cand_c]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = cand_c;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        m_enable_d  = m_enable_q;
        m_addr_d    = m_addr_q;
        m_data_in_d = m_data_in_q;
        m_rw_d      = m_rw_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.m_ready && pick_valid_c) begin
                    sel_d       = pick_idx_c;
                    gnt_d       = NUM_REQ'(1) << pick_idx_c;
                    m_enable_d  = 1'b1;
                    m_addr_d    = addr_arr[pick_idx_c];
                    m_data_in_d = wdata_arr[pick_idx_c];
                    m_rw_d      = bus.req_rw[pick_idx_c];
                    timer_d     = '0;
                    state_d     = S_START;
                end
            end

            S_START, S_BUSY: begin
                if (state_q == S_BUSY && bus.m_ready) begin
                    // Controller finished; a completion on the last cycle still counts
                    if (m_rw_q) begin
                        rdata_d = bus.m_data_out;
                    end
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end else if (timer_q == TMR_LAST) begin
                    // Controller stuck: abort and report err alongside done
                    m_enable_d = 1'b0;
                    rdata_d    = 8'h00;
                    err_d      = 1'b1;
                    done_d     = gnt_q;
                    state_d    = S_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (state_q == S_START && !bus.m_ready) begin
                        m_enable_d = 1'b0;
                        state_d    = S_BUSY;
                    end
                end
            end

            S_DONE: begin
                gnt_d    = '0;
                rr_ptr_d = IDX_W'((32'(sel_q) + 32'd1) % NUM_REQ);
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            m_enable_q  <= 1'b0;
            m_addr_q    <= 7'h00;
            m_data_in_q <= 8'h00;
            m_rw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            m_enable_q  <= m_enable_d;
            m_addr_q    <= m_addr_d;
            m_data_in_q <= m_data_in_d;
            m_rw_q      <= m_rw_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.m_enable  = m_enable_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_data_in = m_data_in_q;
    assign bus.m_rw      = m_rw_q;

endmodule
